// File: rtl/ps2_frame_tx.sv
// Serial frame transmitter: start(0), 8 data bits LSB first, odd parity, stop(1),
// with a generated serial clock whose rising edge lands mid-bit for the receiver.
module ps2_frame_tx #(
  parameter int CLKS_PER_BIT  = 4,
  parameter int IDLE_GAP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       serial_data_out,
  output logic       serial_clk_out,
  output logic       frame_done
);

  localparam int HALF       = CLKS_PER_BIT / 2;
  localparam int CW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_CYCLES = IDLE_GAP_BITS * CLKS_PER_BIT;
  localparam int GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_AT   = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [GW-1:0] GAP_END   = GW'(GAP_LAST);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic [3:0]    bit_idx;
  logic [GW-1:0] gap_cnt;
  logic [9:0]    frame_bits;
  logic          accept;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  assign data_ready = (state == IDLE);
  assign accept     = data_valid && (state == IDLE);

  // Bits 1..10 of the frame; the start bit is driven directly at acceptance.
  always_ff @(posedge clk) begin
    if (accept) frame_bits <= {1'b1, odd_parity(data_in), data_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cyc_cnt         <= '0;
      bit_idx         <= '0;
      gap_cnt         <= '0;
      serial_data_out <= 1'b1;
      serial_clk_out  <= 1'b1;
      frame_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (data_valid) begin
            state           <= SHIFT;
            bit_idx         <= '0;
            cyc_cnt         <= '0;
            serial_data_out <= 1'b0;
            serial_clk_out  <= 1'b0;
          end
        end
        SHIFT: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_idx == 4'd10) begin
              frame_done      <= 1'b0;
              serial_data_out <= 1'b1;
              serial_clk_out  <= 1'b1;
              gap_cnt         <= '0;
              state           <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
              bit_idx         <= bit_idx + 4'd1;
              serial_data_out <= frame_bits[bit_idx];
              serial_clk_out  <= 1'b0;
            end
          end else begin
            cyc_cnt        <= cyc_cnt + 1'b1;
            // Clock rises once the upcoming cycle is in the second half of the bit.
            serial_clk_out <= (cyc_cnt >= HALF_LAST);
            frame_done     <= (bit_idx == 4'd10) && (cyc_cnt == DONE_AT);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_END) state <= IDLE;
          else                    gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_frame_tx.sv
// Bench for ps2_frame_tx: a receiver model on serial_clk_out feeds a scoreboard of
// frames predicted from the byte stream, plus timing monitors for handshake and clock.
module tb_ps2_frame_tx;

  localparam int C          = 4;
  localparam int G          = 1;
  localparam int HALF       = C / 2;
  localparam int FRAME_CYC  = (11 + G) * C;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       serial_data_out;
  logic       serial_clk_out;
  logic       frame_done;

  ps2_frame_tx #(.CLKS_PER_BIT(C), .IDLE_GAP_BITS(G)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .serial_data_out (serial_data_out),
    .serial_clk_out  (serial_clk_out),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;
  int acc_cnt  = 0;
  int last_k   = 0;
  logic [10:0] exp_q[$];

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Expected receiver contents built from the frame definition, bit by bit.
  function automatic logic [10:0] model(input logic [7:0] b);
    logic seq[11];
    logic [10:0] cap;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[i+1] = b[i];
    seq[9]  = ($countones(b) % 2 == 0);
    seq[10] = 1'b1;
    for (int j = 0; j < 11; j++) cap[10-j] = seq[j];
    return cap;
  endfunction

  always @(posedge clk) ecnt <= ecnt + 1;

  // Receiver model and scoreboard check.
  logic [10:0] rx = '0;
  int nbits = 0;
  always @(negedge reset) begin
    nbits = 0;
    rx    = '0;
  end
  always @(posedge serial_clk_out) begin
    if (reset) begin
      rx = {rx[9:0], serial_data_out};
      nbits++;
      if (nbits == 11) begin
        nbits = 0;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_frame", int'(rx), 0);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check(rx == e, "capture", int'(rx), int'(e));
        end
      end
    end
  end

  // Handshake, frame_done and serial clock phase monitor.
  bit in_frame = 0, prev_ready = 1, seen_low = 0;
  int done_cnt = 0, low_run = 0, high_run = 0;
  always @(negedge clk) begin
    if (!reset) begin
      check(serial_data_out && serial_clk_out && data_ready && !frame_done,
            "reset_state", {serial_data_out, serial_clk_out, data_ready, frame_done}, 4'b1110);
      in_frame = 0; done_cnt = 0; low_run = 0; high_run = 0; seen_low = 0;
    end else begin
      if (data_ready && !prev_ready && in_frame) begin
        check(ecnt == last_k + FRAME_CYC, "ready_time", ecnt - last_k, FRAME_CYC);
        check(done_cnt == 1, "done_once", done_cnt, 1);
        in_frame = 0;
      end
      if (frame_done) begin
        done_cnt++;
        check(in_frame, "done_in_frame", in_frame, 1);
        check(ecnt == last_k + 11 * C - 1, "done_time", ecnt - last_k, 11 * C - 1);
      end
      if (data_valid && data_ready) begin
        acc_cnt++;
        last_k   = ecnt + 1;
        in_frame = 1;
        done_cnt = 0;
        seen_low = 0;
      end
      if (!serial_clk_out) begin
        if (high_run > 0 && seen_low) check(high_run == HALF, "clk_high", high_run, HALF);
        high_run = 0;
        low_run++;
        seen_low = 1;
      end else begin
        if (low_run > 0) check(low_run == HALF, "clk_low", low_run, HALF);
        low_run = 0;
        high_run++;
      end
    end
    prev_ready = data_ready;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc();
    int old = acc_cnt;
    int n = 0;
    while (acc_cnt == old && n < 300) begin
      tick();
      n++;
    end
    check(acc_cnt != old, "accept", acc_cnt - old, 1);
  endtask

  task automatic send(input logic [7:0] b, input logic [10:0] e, input bit hold);
    data_in    = b;
    data_valid = 1'b1;
    exp_q.push_back(e);
    wait_acc();
    if (!hold) data_valid = 1'b0;
    data_in = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, rel_e;
    reset      = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'h1C;
    repeat (3) tick();

    exp_q.push_back(11'h0E1);
    reset = 1'b1;
    rel_e = ecnt;
    wait_acc();
    check(last_k == rel_e + 1, "accept_after_reset", last_k - rel_e, 1);
    data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); data_in = 8'($urandom); end

    send(8'h00, 11'h003, 1'b0);
    send(8'hFF, 11'h3FF, 1'b0);

    send(8'hA5, model(8'hA5), 1'b1);
    k1 = last_k;
    for (int i = 0; i < 10; i++) begin tick(); data_in = 8'($urandom); end
    send(8'h5A, model(8'h5A), 1'b0);
    check(last_k - k1 == FRAME_CYC + 1, "b2b_spacing", last_k - k1, FRAME_CYC + 1);

    send(8'h1C, 11'h0E1, 1'b0);
    while (ecnt < last_k + 5 * C) tick();
    check(serial_clk_out == 1'b0, "pre_abort_clk", serial_clk_out, 0);
    reset = 1'b0;
    #1;
    check(serial_data_out && serial_clk_out && data_ready && !frame_done, "abort_lines",
          {serial_data_out, serial_clk_out, data_ready, frame_done}, 4'b1110);
    void'(exp_q.pop_back());
    tick(); tick();
    reset = 1'b1;
    tick();
    send(8'h33, model(8'h33), 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      b = 8'($urandom);
      send(b, model(b), 1'($urandom_range(0, 1)));
    end
    data_valid = 1'b0;

    for (int n = 0; n < 500 && !(data_ready && exp_q.size() == 0); n++) tick();
    tick();
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    check(data_ready == 1'b1, "final_idle", data_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
